dmem_ctrl: RTL

Parametrised, byte-addressable data memory for the CPU's load/store path, with a valid/ready request channel and a registered response channel. Supports RV32 byte, halfword and word loads and stores (signed and unsigned), and optionally splits accesses that cross a word boundary into two beats. Sits between the execute stage's load/store unit and the on-chip data RAM, and flags out-of-range or illegal accesses instead of silently aliasing them.

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_bank.sv | 31 +++
 rtl/dmem_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and pure decode helpers for the data-memory controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } dmem_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte enables across a two-word window: bits [3:0] lower word, [7:4] next word.
    function automatic logic [7:0] byte_en(input logic [2:0] f3, input logic [1:0] boff);
        logic [7:0] base;
        case (f3[1:0])
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << boff;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            F3_B:    return {{24{raw[7]}}, raw[7:0]};
            F3_H:    return {{16{raw[15]}}, raw[15:0]};
            F3_BU:   return {24'h0, raw[7:0]};
            F3_HU:   return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the load/store unit (master) and dmem_ctrl (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port word RAM built from four byte lanes; byte-enabled write, registered read.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rdata;

        always_ff @(posedge clk) begin
            if (i_en && i_we && i_be[gi]) begin
                r_mem[i_addr] <= i_wdata[8*gi +: 8];
            end
            if (i_en && !i_we) begin
                r_rdata <= r_mem[i_addr];
            end
        end

        assign o_rdata[8*gi +: 8] = r_rdata;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory controller: legality checks, lane shifting and
// two-beat splitting of word-crossing accesses in front of a single-port RAM.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(4 * DEPTH_WORDS);

    dmem_state_t   r_state;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic          r_is_load;
    logic          r_split;
    logic [2:0]    r_f3;
    logic [1:0]    r_boff;
    logic [AW-1:0] r_word;
    logic          r_we;
    logic [3:0]    r_be_hi;
    logic [31:0]   r_wdata_hi;
    logic [31:0]   r_lo;

    logic [31:0]   w_off;
    logic [2:0]    w_size;
    logic [7:0]    w_be;
    logic [63:0]   w_wdata_lanes;
    logic          w_f3_bad;
    logic          w_range_bad;
    logic          w_align_bad;
    logic          w_err;
    logic          w_split;
    logic          w_accept;

    logic          w_ram_en;
    logic          w_ram_we;
    logic [3:0]    w_ram_be;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;
    logic [63:0]   w_pair;
    logic [31:0]   w_raw;

    assign w_off         = bus.req_addr - BASE_ADDR;
    assign w_size        = size_bytes(bus.req_funct3);
    assign w_be          = byte_en(bus.req_funct3, w_off[1:0]);
    assign w_wdata_lanes = {32'h0, bus.req_wdata} << {w_off[1:0], 3'b000};

    always_comb begin
        w_f3_bad = 1'b1;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: w_f3_bad = 1'b0;
            F3_BU, F3_HU:     w_f3_bad = bus.req_we;
            default:          w_f3_bad = 1'b1;
        endcase
    end

    // 33-bit sum so an access running past the top of the address space cannot wrap back in.
    assign w_range_bad = ({1'b0, w_off} + {30'h0, w_size}) > MEM_BYTES;
    assign w_align_bad = !MISALIGN_EN &&
                         (((w_size == 3'd2) && w_off[0]) ||
                          ((w_size == 3'd4) && (w_off[1:0] != 2'b00)));
    assign w_err       = w_f3_bad || w_range_bad || w_align_bad;
    assign w_split     = |w_be[7:4];
    assign w_accept    = bus.req_valid && (r_state == IDLE);

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = bus.req_we;
        w_ram_be    = w_be[3:0];
        w_ram_addr  = w_off[AW+1:2];
        w_ram_wdata = w_wdata_lanes[31:0];
        if (r_state == SPLIT) begin
            w_ram_en    = 1'b1;
            w_ram_we    = r_we;
            w_ram_be    = r_be_hi;
            w_ram_addr  = r_word + AW'(1);
            w_ram_wdata = r_wdata_hi;
        end else if (w_accept && !w_err) begin
            w_ram_en = 1'b1;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_is_load   <= 1'b0;
            r_split     <= 1'b0;
            r_f3        <= F3_W;
            r_boff      <= 2'b00;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_be_hi     <= 4'h0;
            r_wdata_hi  <= 32'h0;
            r_lo        <= 32'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_f3       <= bus.req_funct3;
                        r_boff     <= w_off[1:0];
                        r_we       <= bus.req_we;
                        r_word     <= w_off[AW+1:2];
                        r_be_hi    <= w_be[7:4];
                        r_wdata_hi <= w_wdata_lanes[63:32];
                        r_rsp_err  <= w_err;
                        r_is_load  <= !bus.req_we && !w_err;
                        r_split    <= w_split && !w_err;
                        if (w_split && !w_err) begin
                            r_state <= SPLIT;
                        end else begin
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                SPLIT: begin
                    // Beat-1 read data is on the RAM output now; hold it while beat 2 is read.
                    r_lo        <= w_ram_rdata;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_pair = r_split ? {w_ram_rdata, r_lo} : {32'h0, w_ram_rdata};
    assign w_raw  = 32'(w_pair >> {r_boff, 3'b000});

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_valid && r_rsp_err;
    assign bus.rsp_rdata = (r_rsp_valid && r_is_load) ? load_ext(r_f3, w_raw) : 32'h0;

endmodule
